// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: tracks in-flight destinations,
// stalls the IF/ID instruction on RAW hazards and squashes younger work on taken branches.
module pipe_hazard_ctrl #(
  parameter bit              FWD      = 1'b1,
  parameter logic [31:0]     NOP_INST = 32'hFF00_0000,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_use_rs,
  input  logic             ifid_use_rt,
  input  logic             ifid_wr,
  input  logic [4:0]       ifid_wdst,
  input  logic             ifid_load,
  input  logic             mem_br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       load;
    logic [4:0] wdst;
  } slot_t;

  slot_t s_ex_q, s_ex_d;
  slot_t s_mem_q, s_mem_d;
  slot_t s_wb_q, s_wb_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hit_ex, hit_mem, stall_hz;

  // The NOP word is loaded by the pipeline registers themselves; the WB slot is
  // kept only for observability because the register file writes before it reads.
  logic unused_ok;
  assign unused_ok = ^{NOP_INST, s_wb_q};

  function automatic logic slot_match(input slot_t s, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic use_rs, input logic use_rt);
    return s.valid & s.wr & (s.wdst != 5'd0) &
           ((use_rs & (rs == s.wdst)) | (use_rt & (rt == s.wdst)));
  endfunction

  always_comb begin
    hit_ex   = slot_match(s_ex_q, ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt);
    hit_mem  = slot_match(s_mem_q, ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt);
    stall_hz = 1'b0;
    if (FWD) stall_hz = hit_ex & s_ex_q.load;
    else     stall_hz = hit_ex | hit_mem;
    // A taken branch squashes the stalled consumer anyway, so it overrides the hold.
    stall_hz = stall_hz & ~mem_br_taken;
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b1;
    idex_flush  = 1'b1;
    exmem_flush = 1'b1;
    stall       = 1'b0;
    if (rst_n) begin
      pc_en       = ~stall_hz;
      ifid_en     = ~stall_hz;
      ifid_flush  = mem_br_taken;
      idex_flush  = stall_hz | mem_br_taken;
      exmem_flush = mem_br_taken;
      stall       = stall_hz;
    end
  end

  always_comb begin
    s_wb_d  = s_mem_q;
    s_mem_d = mem_br_taken ? slot_t'('0) : s_ex_q;
    s_ex_d  = (stall_hz | mem_br_taken) ? slot_t'('0)
                                        : {1'b1, ifid_wr, ifid_load, ifid_wdst};

    stall_cnt_d = stall_cnt_q;
    if (stall_hz && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_cnt_d = flush_cnt_q;
    if (mem_br_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ex_q      <= '0;
      s_mem_q     <= '0;
      s_wb_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      s_ex_q      <= s_ex_d;
      s_mem_q     <= s_mem_d;
      s_wb_q      <= s_wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: lockstep FWD=1 / FWD=0 instances driven from a vector table,
// plus a narrow-counter instance for saturation.
module tb_pipe_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] ifid_rs, ifid_rt, ifid_wdst;
  logic       ifid_use_rs, ifid_use_rt, ifid_wr, ifid_load, mem_br_taken;

  logic        a_pc_en, a_ifid_en, a_ifid_flush, a_idex_flush, a_exmem_flush, a_stall;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_flush, b_exmem_flush, b_stall;
  logic [15:0] b_stall_cnt, b_flush_cnt;
  logic        c_pc_en, c_ifid_en, c_ifid_flush, c_idex_flush, c_exmem_flush, c_stall;
  logic [3:0]  c_stall_cnt, c_flush_cnt;

  pipe_hazard_ctrl #(.FWD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt), .ifid_wr(ifid_wr),
    .ifid_wdst(ifid_wdst), .ifid_load(ifid_load), .mem_br_taken(mem_br_taken),
    .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush),
    .idex_flush(a_idex_flush), .exmem_flush(a_exmem_flush), .stall(a_stall),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  pipe_hazard_ctrl #(.FWD(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt), .ifid_wr(ifid_wr),
    .ifid_wdst(ifid_wdst), .ifid_load(ifid_load), .mem_br_taken(mem_br_taken),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
    .idex_flush(b_idex_flush), .exmem_flush(b_exmem_flush), .stall(b_stall),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  pipe_hazard_ctrl #(.FWD(1'b0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt), .ifid_wr(ifid_wr),
    .ifid_wdst(ifid_wdst), .ifid_load(ifid_load), .mem_br_taken(mem_br_taken),
    .pc_en(c_pc_en), .ifid_en(c_ifid_en), .ifid_flush(c_ifid_flush),
    .idex_flush(c_idex_flush), .exmem_flush(c_exmem_flush), .stall(c_stall),
    .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt));

  logic [5:0] a_outs, b_outs;
  assign a_outs = {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_flush, a_exmem_flush, a_stall};
  assign b_outs = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_flush, b_exmem_flush, b_stall};

  // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, stall}
  localparam logic [5:0] RUN = 6'b110000;
  localparam logic [5:0] STL = 6'b000101;
  localparam logic [5:0] BR  = 6'b111110;
  localparam logic [5:0] RST = 6'b001110;

  typedef struct {
    logic       r;
    logic [4:0] rs, rt;
    logic       urs, urt, wr, ld;
    logic [4:0] wd;
    logic       br;
    logic [5:0] o;
    logic [15:0] s, f;
    logic [5:0] o_nf;
    logic [15:0] s_nf;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs[NV];

  // ---------------- scoreboard ----------------
  logic [59:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic wr, input logic ld,
                              input logic [4:0] wd, input logic br, input logic [5:0] o,
                              input logic [15:0] s, input logic [15:0] f,
                              input logic [5:0] o_nf, input logic [15:0] s_nf);
    vec_t v;
    v.r = r; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.wr = wr; v.ld = ld;
    v.wd = wd; v.br = br; v.o = o; v.s = s; v.f = f; v.o_nf = o_nf; v.s_nf = s_nf;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst_n = v.r; ifid_rs = v.rs; ifid_rt = v.rt; ifid_use_rs = v.urs; ifid_use_rt = v.urt;
    ifid_wr = v.wr; ifid_load = v.ld; ifid_wdst = v.wd; mem_br_taken = v.br;
    exp_q.push_back({v.o, v.s, v.f, v.o_nf, v.s_nf});
  endtask

  task automatic compare_vec(input int idx);
    logic [59:0] e;
    e = exp_q.pop_front();
    check("outs_fwd1",   idx, 16'(a_outs),  16'(e[59:54]));
    check("stallcnt_fwd1", idx, a_stall_cnt, e[53:38]);
    check("flushcnt_fwd1", idx, a_flush_cnt, e[37:22]);
    check("outs_fwd0",   idx, 16'(b_outs),  16'(e[21:16]));
    check("stallcnt_fwd0", idx, b_stall_cnt, e[15:0]);
    check("flushcnt_fwd0", idx, b_flush_cnt, e[37:22]);
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 0,0,0,0, 0,0, RST,0,0, RST,0);
    vecs[1]  = mk(0, 0, 0, 0,0,0,0, 0,0, RST,0,0, RST,0);
    vecs[2]  = mk(1, 0, 0, 0,0,0,0, 0,0, RUN,0,0, RUN,0);
    vecs[3]  = mk(1, 0, 0, 0,0,1,1, 8,0, RUN,0,0, RUN,0);   // load r8
    vecs[4]  = mk(1, 8, 0, 1,0,0,0, 0,0, STL,0,0, STL,0);   // use r8
    vecs[5]  = mk(1, 8, 0, 1,0,0,0, 0,0, RUN,1,0, STL,1);
    vecs[6]  = mk(1, 0, 0, 0,0,0,0, 0,0, RUN,1,0, RUN,2);
    vecs[7]  = mk(1, 0, 0, 0,0,1,0, 9,0, RUN,1,0, RUN,2);   // alu r9
    vecs[8]  = mk(1, 9, 0, 1,0,0,0, 0,0, RUN,1,0, STL,2);
    vecs[9]  = mk(1, 9, 0, 1,0,0,0, 0,0, RUN,1,0, STL,3);
    vecs[10] = mk(1, 0, 0, 0,0,0,0, 0,0, RUN,1,0, RUN,4);
    vecs[11] = mk(1, 0, 0, 0,0,1,1,12,0, RUN,1,0, RUN,4);   // load r12, consumed via rt
    vecs[12] = mk(1,12,12, 0,1,0,0, 0,0, STL,1,0, STL,4);
    vecs[13] = mk(1,12,12, 0,1,0,0, 0,0, RUN,2,0, STL,5);
    vecs[14] = mk(1, 0, 0, 0,0,1,1,13,0, RUN,2,0, RUN,6);
    vecs[15] = mk(1, 1,13, 1,0,0,0, 0,0, RUN,2,0, RUN,6);   // rt matches but unused
    vecs[16] = mk(1, 0, 0, 0,0,0,0, 0,0, RUN,2,0, RUN,6);
    vecs[17] = mk(1, 0, 0, 0,0,1,1, 0,0, RUN,2,0, RUN,6);   // load to $0
    vecs[18] = mk(1, 0, 0, 1,0,0,0, 0,0, RUN,2,0, RUN,6);
    vecs[19] = mk(1, 0, 0, 0,0,0,0, 0,0, RUN,2,0, RUN,6);
    vecs[20] = mk(1, 0, 0, 0,0,1,1,10,0, RUN,2,0, RUN,6);
    vecs[21] = mk(1,10, 0, 1,0,0,0, 0,1, BR ,2,0, BR ,6);   // load-use + branch
    vecs[22] = mk(1,10, 0, 1,0,0,0, 0,0, RUN,2,1, RUN,6);
    vecs[23] = mk(1, 0, 0, 0,0,0,0, 0,0, RUN,2,1, RUN,6);
    vecs[24] = mk(1, 0, 0, 0,0,1,1,11,0, RUN,2,1, RUN,6);
    vecs[25] = mk(1, 0, 0, 0,0,1,1,11,0, RUN,2,1, RUN,6);
    vecs[26] = mk(1, 0, 0, 0,0,0,0, 0,1, BR ,2,1, BR ,6);   // squash both loads
    vecs[27] = mk(1,11, 0, 1,0,0,0, 0,0, RUN,2,2, RUN,6);
    vecs[28] = mk(1, 0, 0, 0,0,1,1,14,0, RUN,2,2, RUN,6);
    vecs[29] = mk(1,14, 0, 1,0,0,0, 0,0, STL,2,2, STL,6);
    vecs[30] = mk(0,14, 0, 1,0,0,0, 0,0, RST,3,2, RST,7);   // reset mid-stall
    vecs[31] = mk(1,14, 0, 1,0,1,1,14,0, RUN,0,0, RUN,0);
    vecs[32] = mk(1,14, 0, 1,0,0,0, 0,0, STL,0,0, STL,0);
    vecs[33] = mk(1,14, 0, 1,0,0,0, 0,0, RUN,1,0, STL,1);
    vecs[34] = mk(1, 0, 0, 0,0,0,0, 0,0, RUN,1,0, RUN,2);

    rst_n = 1'b0; ifid_rs = '0; ifid_rt = '0; ifid_use_rs = 1'b0; ifid_use_rt = 1'b0;
    ifid_wr = 1'b0; ifid_load = 1'b0; ifid_wdst = '0; mem_br_taken = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      compare_vec(i);
    end

    // Saturation: FWD=0 with a self-dependent writer stalls 2 of every 3 cycles.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; ifid_rs = 5'd8; ifid_use_rs = 1'b1; ifid_use_rt = 1'b0;
    ifid_wr = 1'b1; ifid_load = 1'b0; ifid_wdst = 5'd8; mem_br_taken = 1'b0;
    exp_q.push_back(60'(16'h000F));
    exp_q.push_back(60'(16'd19));
    repeat (29) @(posedge clk);   // 19 stall cycles
    @(negedge clk);
    check("sat_stallcnt_w4",   100, 16'(c_stall_cnt), 16'(exp_q.pop_front()));
    check("nosat_stallcnt_w16", 101, b_stall_cnt,      16'(exp_q.pop_front()));

    mem_br_taken = 1'b1;
    exp_q.push_back(60'(16'h000F));
    exp_q.push_back(60'(16'd19));
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("sat_flushcnt_w4",   102, 16'(c_flush_cnt), 16'(exp_q.pop_front()));
    check("nosat_flushcnt_w16", 103, b_flush_cnt,      16'(exp_q.pop_front()));
    check("sat_stall_held_w4", 104, 16'(c_stall_cnt), 16'h000F);
    check("stall_frozen_br_w16", 105, b_stall_cnt,    16'd19);
    check("br_overrides_stall", 106, 16'({c_pc_en, c_stall, c_idex_flush}), 16'(3'b101));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Keeps a shadow scoreboard of the destination registers of in-flight instructions.
- Detects RAW hazards on the instruction currently in IF/ID and generates PC/IF-ID hold enables and per-stage flush (NOP-injection) controls.
- Squashes younger instructions when a branch resolves taken in EX/MEM, and keeps saturating stall/flush event counters.

Parameters:
- FWD, 1, 1 = EX/MEM and MEM/WB forwarding exists, so only load-use stalls; 0 = stall on any RAW against ID/EX or EX/MEM.
- NOP_INST, 32'hFF000000, instruction word the pipeline registers load when flushed.
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- ifid_rs  in  5  rs field of the IF/ID instruction.
- ifid_rt  in  5  rt field of the IF/ID instruction.
- ifid_use_rs  in  1  IF/ID instruction reads rs.
- ifid_use_rt  in  1  IF/ID instruction reads rt.
- ifid_wr  in  1  IF/ID instruction writes the register file.
- ifid_wdst  in  5  destination register of the IF/ID instruction (after RegDst mux).
- ifid_load  in  1  IF/ID instruction is a load.
- mem_br_taken  in  1  branch in EX/MEM resolved taken this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable; 0 = hold.
- ifid_flush  out  1  IF/ID loads NOP_INST.
- idex_flush  out  1  ID/EX loads NOP_INST (bubble).
- exmem_flush  out  1  EX/MEM loads NOP_INST.
- stall  out  1  hazard stall active (debug).
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of taken-branch flush events.

Behaviour:
- Scoreboard:
  - Three registered slots: S_EX (instruction in ID/EX), S_MEM (EX/MEM), S_WB (MEM/WB).
  - Each slot holds {valid, wr, load, wdst[4:0]}.
  - The register file writes before it reads, so S_WB never causes a hazard; it is tracked for debug and symmetry only.
- Match condition for a slot: valid & wr & wdst != 0 & ((ifid_use_rs & rs == wdst) | (ifid_use_rt & rt == wdst)).
- Stall (combinational):
  - FWD=1: stall = match(S_EX) & S_EX.load.
  - FWD=0: stall = match(S_EX) | match(S_MEM).
  - Stall is forced to 0 whenever mem_br_taken = 1.
- Output equations when rst_n = 1:
  - pc_en = ifid_en = ~stall.
  - ifid_flush = mem_br_taken.
  - idex_flush = stall | mem_br_taken.
  - exmem_flush = mem_br_taken.
- Scoreboard update at each rising edge (rst_n = 1):
  - S_WB <= S_MEM.
  - S_MEM <= mem_br_taken ? invalid : S_EX.
  - S_EX <= (stall | mem_br_taken) ? invalid : {1, ifid_wr, ifid_load, ifid_wdst}.
- Latencies:
  - Load-use stall lasts exactly 1 cycle when FWD=1.
  - When FWD=0, a stall lasts 2 cycles against S_EX and 1 cycle against S_MEM.
  - Branch penalty: 3 squashed instructions, reported as a single flush event.
- Simultaneous stall and branch: the branch wins. No hold; all three flushes assert; stall_cnt does not increment.
- Counters:
  - stall_cnt += 1 each cycle stall = 1.
  - flush_cnt += 1 each cycle mem_br_taken = 1.
  - Both saturate at all-ones; no wrap.
- Reset, while rst_n = 0 (synchronous, takes effect at the edge; outputs forced combinationally while low):
  - pc_en = ifid_en = 0; ifid_flush = idex_flush = exmem_flush = 1; stall = 0.
  - All slots invalid; both counters 0.
  - The first cycle after reset deassertion is hazard-free.
- Reset mid-stall: the stall drops, the scoreboard clears, and there is no residual bubble count.

Test Plan:
- Load-use, FWD=1: cycle 0: ifid_load=1, ifid_wr=1, ifid_wdst=8. Cycle 1: ifid_rs=8, ifid_use_rs=1. Required: cycle 1 has stall=1, pc_en=0, ifid_en=0, idex_flush=1; cycle 2 has stall=0; stall_cnt=1.
- ALU RAW, FWD=1: same sequence with ifid_load=0 -> no stall in any cycle; stall_cnt=0. Rerun with FWD=0 -> stall=1 for 2 consecutive cycles; stall_cnt=2.
- Register $0: load to wdst=0 followed by a use of rs=0 -> no stall.
- Taken branch: mem_br_taken=1 for 1 cycle -> ifid_flush, idex_flush and exmem_flush all 1 in that cycle with pc_en=1; S_EX and S_MEM invalid afterwards; flush_cnt=1. A consumer of a squashed load's wdst in the next cycle does not stall.
- Simultaneous hazard and branch: load-use condition and mem_br_taken=1 in the same cycle -> stall=0, pc_en=1, all flushes 1; stall_cnt unchanged; flush_cnt incremented.
- Reset: rst_n=0 during an active stall -> at the next edge and while low, pc_en=0 and all flushes 1. After release: stall_cnt=0, flush_cnt=0, and a back-to-back dependent pair evaluated only against new slots. Counter saturation: force 2^CNT_W+3 stall cycles -> stall_cnt holds 16'hFFFF.
